// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - direct-mapped read-only instruction cache
// Hits answer in the request cycle; misses fetch one word over the iREN/iwait handshake.
module icache_responder #(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  input  logic        invalidate,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t             r_state;
  logic [29:0]        r_miss_word;
  logic [SETS-1:0]    r_valid;
  logic [TAG_W-1:0]   r_tag  [SETS];
  logic [31:0]        r_data [SETS];
  logic [31:0]        r_hit_count;
  logic [31:0]        r_miss_count;

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [IDX_W-1:0]   w_fill_idx;
  logic [TAG_W-1:0]   w_fill_tag;
  logic               w_match;
  logic               w_start_miss;

  assign w_idx      = imemaddr[IDX_W+1:2];
  assign w_tag      = imemaddr[31:IDX_W+2];
  assign w_fill_idx = r_miss_word[IDX_W-1:0];
  assign w_fill_tag = r_miss_word[29:IDX_W];

  assign w_match      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_start_miss = (r_state == IDLE) && imemREN && !w_match && !invalidate;

  assign ihit       = imemREN && w_match && (r_state == IDLE);
  assign imemload   = ihit ? r_data[w_idx] : 32'd0;
  assign iREN       = (r_state == FETCH);
  assign iaddr      = {r_miss_word, 2'b00};
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_miss_word  <= '0;
      r_valid      <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
      for (int i = 0; i < SETS; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (ihit && (r_hit_count != 32'hFFFF_FFFF))
        r_hit_count <= r_hit_count + 32'd1;

      case (r_state)
        IDLE: begin
          if (w_start_miss) begin
            r_miss_word <= imemaddr[31:2];
            r_state     <= FETCH;
            if (r_miss_count != 32'hFFFF_FFFF)
              r_miss_count <= r_miss_count + 32'd1;
          end
        end
        FETCH: begin
          // An invalidate landing on the fill edge drops the returning word.
          if (!iwait) begin
            if (!invalidate) begin
              r_valid[w_fill_idx] <= 1'b1;
              r_tag[w_fill_idx]   <= w_fill_tag;
              r_data[w_fill_idx]  <= iload;
            end
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (invalidate)
        r_valid <= '0;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// tb/tb_icache_responder.sv - scoreboard bench for icache_responder
// Expected fill words are queued when a miss is driven and popped when the hit appears.
module tb_icache_responder;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = '0;
  logic        invalidate = 1'b0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] exp_miss = 0;
  logic [31:0] exp_data;
  logic [31:0] sb_q[$];

  icache_responder #(.SETS(16)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .invalidate(invalidate),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Drives a full miss on addr with nw busy cycles, then returns the fill word; ends in the first IDLE cycle.
  task automatic fill(input logic [31:0] a, input logic [31:0] d, input int nw);
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = 1'b1;
    sb_q.push_back(d);
    exp_miss = exp_miss + 1;
    step();
    repeat (nw) step();
    iwait = 1'b0;
    iload = d;
    step();
    iwait = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (ihit !== 1'b0) $display("FAIL reset_ihit: got %b want 0", ihit); else passed++;
    checks++; if (imemload !== 32'd0) $display("FAIL reset_imemload: got %h want 0", imemload); else passed++;
    checks++; if (iREN !== 1'b0) $display("FAIL reset_iREN: got %b want 0", iREN); else passed++;
    checks++; if (iaddr !== 32'd0) $display("FAIL reset_iaddr: got %h want 0", iaddr); else passed++;
    checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0)
      $display("FAIL reset_counters: got %0d/%0d want 0/0", hit_count, miss_count); else passed++;
    nRST = 1'b1;
  endtask

  task automatic test_miss_fill();
    step();
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0000;
    iwait    = 1'b1;
    sb_q.push_back(32'h2001_0005);
    #1;
    checks++; if (ihit !== 1'b0) $display("FAIL miss_req_ihit: got %b want 0", ihit); else passed++;
    step();
    exp_miss = exp_miss + 1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (iREN !== 1'b1 || iaddr !== 32'h0 || ihit !== 1'b0)
        $display("FAIL miss_fetch_%0d: iREN=%b iaddr=%h ihit=%b want 1/0/0", i, iREN, iaddr, ihit); else passed++;
      if (i < 2) step();
    end
    iwait = 1'b0;
    iload = 32'h2001_0005;
    step();
    iwait = 1'b1;
    exp_data = sb_q.pop_front();
    checks++; if (ihit !== 1'b1 || imemload !== exp_data)
      $display("FAIL miss_fill_hit: ihit=%b data=%h want 1/%h", ihit, imemload, exp_data); else passed++;
    checks++; if (miss_count !== exp_miss) $display("FAIL miss_count1: got %0d want %0d", miss_count, exp_miss); else passed++;
  endtask

  task automatic test_hits();
    checks++; if (hit_count !== 32'd0) $display("FAIL hits_start: got %0d want 0", hit_count); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (ihit !== 1'b1 || iREN !== 1'b0 || imemload !== 32'h2001_0005)
        $display("FAIL hits_cycle_%0d: ihit=%b iREN=%b data=%h want 1/0/20010005", i, ihit, iREN, imemload); else passed++;
      step();
    end
    imemREN = 1'b0;
    checks++; if (hit_count !== 32'd4) $display("FAIL hits_count: got %0d want 4", hit_count); else passed++;
  endtask

  task automatic test_conflict();
    fill(32'h0000_0040, 32'hBBBB_0040, 1);
    exp_data = sb_q.pop_front();
    checks++; if (ihit !== 1'b1 || imemload !== exp_data)
      $display("FAIL conflict_hit40: ihit=%b data=%h want 1/%h", ihit, imemload, exp_data); else passed++;
    imemaddr = 32'h0000_0000;
    #1;
    checks++; if (ihit !== 1'b0) $display("FAIL conflict_remiss: got %b want 0", ihit); else passed++;
    exp_miss = exp_miss + 1;
    sb_q.push_back(32'hAAAA_0000);
    step();
    checks++; if (iREN !== 1'b1 || iaddr !== 32'h0)
      $display("FAIL conflict_iaddr: iREN=%b iaddr=%h want 1/0", iREN, iaddr); else passed++;
    iwait = 1'b0;
    iload = 32'hAAAA_0000;
    step();
    iwait = 1'b1;
    exp_data = sb_q.pop_front();
    checks++; if (ihit !== 1'b1 || imemload !== exp_data)
      $display("FAIL conflict_refill: ihit=%b data=%h want 1/%h", ihit, imemload, exp_data); else passed++;
  endtask

  task automatic test_redirect();
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0008;
    exp_miss = exp_miss + 1;
    step();
    imemaddr = 32'h0000_0100;
    #1;
    checks++; if (iaddr !== 32'h8 || ihit !== 1'b0)
      $display("FAIL redirect_hold0: iaddr=%h ihit=%b want 8/0", iaddr, ihit); else passed++;
    step();
    checks++; if (iaddr !== 32'h8 || iREN !== 1'b1)
      $display("FAIL redirect_hold1: iaddr=%h iREN=%b want 8/1", iaddr, iREN); else passed++;
    iwait = 1'b0;
    iload = 32'hD000_0008;
    step();
    iwait = 1'b1;
    checks++; if (ihit !== 1'b0) $display("FAIL redirect_newmiss: got %b want 0", ihit); else passed++;
    exp_miss = exp_miss + 1;
    sb_q.push_back(32'hD000_0100);
    step();
    checks++; if (iaddr !== 32'h100 || iREN !== 1'b1)
      $display("FAIL redirect_fetch100: iaddr=%h iREN=%b want 100/1", iaddr, iREN); else passed++;
    iwait = 1'b0;
    iload = 32'hD000_0100;
    step();
    iwait = 1'b1;
    exp_data = sb_q.pop_front();
    checks++; if (ihit !== 1'b1 || imemload !== exp_data)
      $display("FAIL redirect_hit100: ihit=%b data=%h want 1/%h", ihit, imemload, exp_data); else passed++;
    sb_q.push_back(32'hD000_0008);
    imemaddr = 32'h0000_0008;
    #1;
    exp_data = sb_q.pop_front();
    checks++; if (ihit !== 1'b1 || imemload !== exp_data)
      $display("FAIL redirect_hit8: ihit=%b data=%h want 1/%h", ihit, imemload, exp_data); else passed++;
    checks++; if (miss_count !== exp_miss) $display("FAIL redirect_misses: got %0d want %0d", miss_count, exp_miss); else passed++;
  endtask

  task automatic test_invalidate();
    imemaddr = 32'h0000_000C;
    exp_miss = exp_miss + 1;
    step();
    iwait      = 1'b0;
    iload      = 32'hDEAD_000C;
    invalidate = 1'b1;
    step();
    invalidate = 1'b0;
    iwait      = 1'b1;
    checks++; if (ihit !== 1'b0 || iREN !== 1'b0)
      $display("FAIL inval_fill_dropped: ihit=%b iREN=%b want 0/0", ihit, iREN); else passed++;
    imemaddr = 32'h0000_0008;
    #1;
    checks++; if (ihit !== 1'b0) $display("FAIL inval_all_cleared: got %b want 0", ihit); else passed++;
    imemaddr = 32'h0000_000C;
    exp_miss = exp_miss + 1;
    sb_q.push_back(32'hCAFE_000C);
    step();
    checks++; if (iREN !== 1'b1 || iaddr !== 32'hC)
      $display("FAIL inval_refetch: iREN=%b iaddr=%h want 1/c", iREN, iaddr); else passed++;
    iwait = 1'b0;
    iload = 32'hCAFE_000C;
    step();
    iwait = 1'b1;
    exp_data = sb_q.pop_front();
    checks++; if (ihit !== 1'b1 || imemload !== exp_data)
      $display("FAIL inval_refill_hit: ihit=%b data=%h want 1/%h", ihit, imemload, exp_data); else passed++;
    fill(32'h0000_0008, 32'h1234_0008, 0);
    exp_data = sb_q.pop_front();
    checks++; if (ihit !== 1'b1 || imemload !== exp_data)
      $display("FAIL inval_fill8: ihit=%b data=%h want 1/%h", ihit, imemload, exp_data); else passed++;
    imemaddr   = 32'h0000_0020;
    invalidate = 1'b1;
    step();
    invalidate = 1'b0;
    checks++; if (iREN !== 1'b0) $display("FAIL inval_idle_nomiss: iREN=%b want 0", iREN); else passed++;
    checks++; if (miss_count !== exp_miss) $display("FAIL inval_misses: got %0d want %0d", miss_count, exp_miss); else passed++;
    imemaddr = 32'h0000_000C;
    #1;
    checks++; if (ihit !== 1'b0) $display("FAIL inval_idle_c: got %b want 0", ihit); else passed++;
    imemaddr = 32'h0000_0008;
    #1;
    checks++; if (ihit !== 1'b0) $display("FAIL inval_idle_8: got %b want 0", ihit); else passed++;
    imemREN = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    step();
    fill(32'h0000_0010, 32'h5555_0010, 0);
    exp_data = sb_q.pop_front();
    checks++; if (ihit !== 1'b1 || imemload !== exp_data)
      $display("FAIL rst_prefill: ihit=%b data=%h want 1/%h", ihit, imemload, exp_data); else passed++;
    imemaddr = 32'h0000_0014;
    step();
    checks++; if (iREN !== 1'b1 || iaddr !== 32'h14)
      $display("FAIL rst_in_fetch: iREN=%b iaddr=%h want 1/14", iREN, iaddr); else passed++;
    #2;
    nRST = 1'b0;
    #1;
    checks++; if (iREN !== 1'b0 || iaddr !== 32'h0 || ihit !== 1'b0 || imemload !== 32'h0)
      $display("FAIL rst_async_outs: iREN=%b iaddr=%h ihit=%b data=%h want 0/0/0/0", iREN, iaddr, ihit, imemload); else passed++;
    checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0)
      $display("FAIL rst_async_counters: got %0d/%0d want 0/0", hit_count, miss_count); else passed++;
    exp_miss = 0;
    step();
    iwait = 1'b0;
    iload = 32'hFFFF_FFFF;
    nRST  = 1'b1;
    imemaddr = 32'h0000_0010;
    #1;
    checks++; if (ihit !== 1'b0) $display("FAIL rst_prior_miss: got %b want 0", ihit); else passed++;
    imemREN = 1'b0;
    iwait   = 1'b1;
    checks++; if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d want 0", sb_q.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_hits();
    test_conflict();
    test_redirect();
    test_invalidate();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Direct-mapped, read-only instruction cache.
- Answers the datapath fetch request (imemREN/imemaddr) with ihit/imemload.
- On a miss, fetches one word from the memory controller through an iREN/iaddr/iwait/iload handshake.
- Sits between the pipeline fetch stage and the memory controller. Exposes hit/miss counters for performance runs.

Parameters:
- SETS, 16, number of one-word frames; power of two, minimum 2.
- IDX_W, $clog2(SETS), index width.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- imemREN  in  1  datapath fetch request
- imemaddr  in  32  datapath fetch byte address; bits [1:0] ignored
- ihit  out  1  requested word valid this cycle
- imemload  out  32  instruction word; 0 when ihit=0
- iREN  out  1  read request to memory controller
- iaddr  out  32  word-aligned miss address to memory controller
- iwait  in  1  memory busy; fill data is valid in the cycle iwait=0 while iREN=1
- iload  in  32  fill data from memory
- invalidate  in  1  single-cycle pulse; clears all valid bits
- hit_count  out  32  cycles with ihit=1
- miss_count  out  32  number of misses issued

Behaviour:
- Clock and reset: one clock CLK; reset nRST is asynchronous, active-low.
- Address split:
  - index = imemaddr[IDX_W+1:2]
  - tag = imemaddr[31:IDX_W+2]
- Storage per frame: valid, tag, 32-bit data.
- Reset values:
  - all valid=0; tags and data=0; state=IDLE; miss_addr=0; counters=0.
  - Outputs: ihit=0, imemload=0, iREN=0, iaddr=0.
- Hit detect (combinational): match = valid[index] && tag[index]==addr tag.
- ihit = imemREN && match && state==IDLE. imemload = data[index] when ihit, else 0.
- FSM states: IDLE, FETCH.
- IDLE:
  - If imemREN && !match && !invalidate: latch miss_addr={imemaddr[31:2],2'b00}, go to FETCH, increment miss_count.
  - Otherwise stay in IDLE.
  - iREN=0.
- FETCH:
  - iREN=1, iaddr=miss_addr; ihit=0.
  - If iwait=0: at the clock edge write data=iload, tag and valid=1 into frame miss_addr index, then go to IDLE.
  - If iwait=1: stay in FETCH.
- Latency:
  - Hit: 0 cycles; same cycle as the request.
  - Miss: request cycle, then >=1 FETCH cycle, then a hit in the first IDLE cycle after the fill. Minimum 2 cycles with ihit=0.
- Request withdrawn or changed during FETCH (imemREN drop, branch redirect): the fill still completes for miss_addr. The new imemaddr is evaluated only after return to IDLE. It may miss again.
- invalidate:
  - Clears all valid bits at the edge.
  - In FETCH, the completing fill is discarded (not written); state still returns to IDLE when iwait=0.
  - invalidate has priority over a same-edge fill.
  - In IDLE, a same-cycle miss is not started (ihit=0 that cycle).
- Conflict: a fill to an occupied index overwrites tag/data unconditionally; no replacement choice.
- Counters:
  - hit_count increments every cycle ihit=1; datapath stalls count repeatedly.
  - miss_count increments on each IDLE->FETCH transition.
  - Both saturate at 32'hFFFF_FFFF; no wrap.
- Reset mid-FETCH: immediately returns to IDLE, invalid frames, iREN=0. The in-flight memory response is ignored.
- iaddr holds miss_addr in IDLE; iREN is the only qualifier.

Test Plan:
- Reset, then imemREN=1, addr 0x0000_0000 → ihit=0; next cycle iREN=1, iaddr=0x0. Drive iwait=1 for 3 cycles, then iwait=0 with iload=0x2001_0005 → next cycle ihit=1, imemload=0x2001_0005, miss_count=1.
- Re-fetch 0x0 for 4 cycles → ihit=1 every cycle, hit_count increases by 4, iREN stays 0.
- Conflict (SETS=16): fill 0x0 (data A), then fetch 0x40 (fill data B) → 0x40 hits with B. Re-fetch 0x0 → miss; iaddr=0x0 in FETCH.
- Redirect: miss on 0x8, change imemaddr to 0x100 during FETCH with iwait=1 → iaddr stays 0x8. After fill, 0x100 misses, then 0x8 hits.
- invalidate pulse at the same edge iwait=0 in FETCH → frame not written, state IDLE; the same address misses again. A later invalidate in IDLE makes all previously valid addresses miss.
- Assert nRST low mid-FETCH → iREN=0 and all outputs reset asynchronously. After release, the prior address misses; counters=0.
